// File: rtl/yolo_pkg.sv
// -----------------------------------------------------------------------------
// yolo_pkg
// Shared definitions for the YOLO box post-processing blocks.
//   Data_bit        : width of every coordinate / confidence word (signed Q format)
//   layer_shift_bit : fractional bits of coordinates and confidence
//   CLASS_BIT       : class index width
//   IMG_MAX         : upper clamp for box corners (grid units, same Q format)
//   box_entry_t     : one buffered candidate, field order MSB..LSB:
//                     x0, y0, x1, y1, conf, cls, keep, last
// -----------------------------------------------------------------------------
package yolo_pkg;

    localparam int Data_bit        = 16;
    localparam int layer_shift_bit = 10;
    localparam int CLASS_BIT       = 8;

    localparam logic [Data_bit-1:0] IMG_MAX = Data_bit'(13 << layer_shift_bit);

    typedef struct packed {
        logic [Data_bit-1:0]  x0;
        logic [Data_bit-1:0]  y0;
        logic [Data_bit-1:0]  x1;
        logic [Data_bit-1:0]  y1;
        logic [Data_bit-1:0]  conf;
        logic [CLASS_BIT-1:0] cls;
        logic                 keep;
        logic                 last;
    } box_entry_t;

    localparam int ENTRY_W = $bits(box_entry_t);

endpackage

// File: rtl/yolo_box_fifo.sv
// -----------------------------------------------------------------------------
// yolo_box_fifo
// Show-ahead synchronous FIFO: head always presents the oldest entry.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN : clock, synchronous active-low reset
//   push, push_data           : write request and entry
//   pop                       : consume head (ignored when empty)
//   head                      : oldest entry (valid when !empty)
//   empty, full, count        : occupancy status
// -----------------------------------------------------------------------------
module yolo_box_fifo #(
    parameter int WIDTH = 90,
    parameter int DEPTH = 16
) (
    input  logic                     M_AXI_ACLK,
    input  logic                     M_AXI_ARESETN,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit, so the difference is the occupancy.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/yolo_box_candidate_buffer.sv
// -----------------------------------------------------------------------------
// yolo_box_candidate_buffer
// Filters decoded YOLO boxes by objectness, converts centre/size to clamped
// corners and buffers survivors for the IOU/NMS stage.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN        : clock, synchronous active-low reset
//   conf_thresh                      : unsigned objectness threshold
//   in_valid, in_bx, in_by, in_bw, in_bh, in_conf, in_class, in_last : box beat
//   out_valid, out_ready             : show-ahead handshake to consumer
//   out_x0, out_y0, out_x1, out_y1, out_conf, out_class, out_keep, out_last
//   almost_full                      : count >= FIFO_DEPTH-AFULL_MARGIN
//   drop_cnt                         : saturating count of kept boxes lost to full FIFO
//   frame_box_cnt                    : boxes written in the last completed frame
// -----------------------------------------------------------------------------
module yolo_box_candidate_buffer
    import yolo_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                 M_AXI_ACLK,
    input  logic                 M_AXI_ARESETN,
    input  logic [Data_bit-1:0]  conf_thresh,
    input  logic                 in_valid,
    input  logic [Data_bit-1:0]  in_bx,
    input  logic [Data_bit-1:0]  in_by,
    input  logic [Data_bit-1:0]  in_bw,
    input  logic [Data_bit-1:0]  in_bh,
    input  logic [Data_bit-1:0]  in_conf,
    input  logic [CLASS_BIT-1:0] in_class,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Data_bit-1:0]  out_x0,
    output logic [Data_bit-1:0]  out_y0,
    output logic [Data_bit-1:0]  out_x1,
    output logic [Data_bit-1:0]  out_y1,
    output logic [Data_bit-1:0]  out_conf,
    output logic [CLASS_BIT-1:0] out_class,
    output logic                 out_keep,
    output logic                 out_last,
    output logic                 almost_full,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          frame_box_cnt
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);

    function automatic logic [Data_bit-1:0] clamp_corner(input logic signed [Data_bit:0] v);
        if (v[Data_bit])                return '0;
        if (v[Data_bit-1:0] > IMG_MAX)  return IMG_MAX;
        return v[Data_bit-1:0];
    endfunction

    // ---- S1: input register and confidence filter ----
    logic signed [Data_bit-1:0] bx_p1, by_p1, bw_p1, bh_p1;
    logic [Data_bit-1:0]        conf_p1;
    logic [CLASS_BIT-1:0]       cls_p1;
    logic                       keep_p1, last_p1;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            keep_p1 <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            keep_p1 <= in_valid & (in_conf >= conf_thresh);
            last_p1 <= in_valid & in_last;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        bx_p1   <= in_bx;
        by_p1   <= in_by;
        bw_p1   <= in_bw;
        bh_p1   <= in_bh;
        conf_p1 <= in_conf;
        cls_p1  <= in_class;
    end

    // ---- S2: corner conversion (one extra bit so negative/overflow is visible), clamp ----
    logic signed [Data_bit-1:0] hw_p1, hh_p1;
    logic signed [Data_bit:0]   x0_w, y0_w, x1_w, y1_w;
    box_entry_t                 ent_p2;
    logic                       keep_p2, last_p2;

    always_comb begin
        hw_p1 = bw_p1 >>> 1;
        hh_p1 = bh_p1 >>> 1;
        x0_w  = {bx_p1[Data_bit-1], bx_p1} - {hw_p1[Data_bit-1], hw_p1};
        x1_w  = {bx_p1[Data_bit-1], bx_p1} + {hw_p1[Data_bit-1], hw_p1};
        y0_w  = {by_p1[Data_bit-1], by_p1} - {hh_p1[Data_bit-1], hh_p1};
        y1_w  = {by_p1[Data_bit-1], by_p1} + {hh_p1[Data_bit-1], hh_p1};
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            keep_p2 <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            keep_p2 <= keep_p1;
            last_p2 <= last_p1;
        end
    end

    // Rejected beats that only carry last become markers with zeroed payload.
    always_ff @(posedge M_AXI_ACLK) begin
        ent_p2.x0   <= keep_p1 ? clamp_corner(x0_w) : '0;
        ent_p2.y0   <= keep_p1 ? clamp_corner(y0_w) : '0;
        ent_p2.x1   <= keep_p1 ? clamp_corner(x1_w) : '0;
        ent_p2.y1   <= keep_p1 ? clamp_corner(y1_w) : '0;
        ent_p2.conf <= keep_p1 ? conf_p1 : '0;
        ent_p2.cls  <= keep_p1 ? cls_p1  : '0;
        ent_p2.keep <= 1'b0;
        ent_p2.last <= 1'b0;
    end

    // ---- push arbitration, overflow handling, FIFO ----
    logic             fifo_empty, fifo_full, pop_req, can_accept;
    logic             push, drop_now, set_pending, clr_pending, last_pending;
    box_entry_t       push_data, head_ent, fifo_head;
    logic [AW:0]      fifo_count;
    logic [15:0]      run_cnt;

    always_comb begin
        pop_req     = ~fifo_empty & out_ready;
        can_accept  = ~fifo_full | pop_req;
        push        = 1'b0;
        push_data   = ent_p2;
        push_data.keep = keep_p2;
        push_data.last = last_p2;
        drop_now    = 1'b0;
        set_pending = 1'b0;
        clr_pending = 1'b0;
        if (keep_p2 | last_p2) begin
            if (can_accept) begin
                push = 1'b1;
            end else begin
                drop_now    = keep_p2;
                set_pending = last_p2;
            end
        end else if (last_pending && !fifo_full) begin
            // A frame end lost to overflow is re-issued as a bare marker.
            push           = 1'b1;
            push_data      = '0;
            push_data.last = 1'b1;
            clr_pending    = 1'b1;
        end
    end

    yolo_box_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .push          (push),
        .push_data     (push_data),
        .pop           (pop_req),
        .head          (fifo_head),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .count         (fifo_count)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            last_pending  <= 1'b0;
            drop_cnt      <= '0;
            run_cnt       <= '0;
            frame_box_cnt <= '0;
        end else begin
            if (set_pending)      last_pending <= 1'b1;
            else if (clr_pending) last_pending <= 1'b0;
            if (drop_now && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (push) begin
                if (push_data.last) begin
                    frame_box_cnt <= run_cnt + 16'(push_data.keep);
                    run_cnt       <= '0;
                end else begin
                    run_cnt <= run_cnt + 16'(push_data.keep);
                end
            end
        end
    end

    // Head payload is forced to zero while empty so outputs are 0 out of reset.
    assign head_ent    = fifo_empty ? '0 : fifo_head;
    assign out_valid   = ~fifo_empty;
    assign out_x0      = head_ent.x0;
    assign out_y0      = head_ent.y0;
    assign out_x1      = head_ent.x1;
    assign out_y1      = head_ent.y1;
    assign out_conf    = head_ent.conf;
    assign out_class   = head_ent.cls;
    assign out_keep    = head_ent.keep;
    assign out_last    = head_ent.last;
    assign almost_full = (fifo_count >= AFULL_LVL);

endmodule
